// File: rtl/keyboard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_pkg : PS/2 Set-2 scancodes and prefix-decoder state encoding
// Revision 1.0
// ---------------------------------------------------------------------------
package keyboard_pkg;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

endpackage : keyboard_pkg
`default_nettype wire

// File: rtl/kbd_prefix_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// kbd_prefix_fsm : tracks F0/E0 prefixes, qualifies each final scancode byte
// Revision 1.0
// ---------------------------------------------------------------------------
module kbd_prefix_fsm
    import keyboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [7:0] code,
    output logic       is_make,
    output logic       is_break,
    output logic       is_ext
);

    kbd_state_t r_state;

    // Qualifiers are combinational so the flags update on the edge that
    // consumes the final byte of a sequence.
    always_comb begin
        code     = rx_data;
        is_make  = 1'b0;
        is_break = 1'b0;
        is_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        if (rx_done_tick) begin
            unique case (r_state)
                ST_IDLE:    is_make  = (rx_data != SC_BREAK) && (rx_data != SC_EXT);
                ST_EXT:     is_make  = (rx_data != SC_BREAK);
                ST_BRK,
                ST_EXT_BRK: is_break = 1'b1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (rx_done_tick) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data == SC_BREAK)    r_state <= ST_BRK;
                    else if (rx_data == SC_EXT) r_state <= ST_EXT;
                    else                        r_state <= ST_IDLE;
                end
                ST_EXT: begin
                    if (rx_data == SC_BREAK) r_state <= ST_EXT_BRK;
                    else                     r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : kbd_prefix_fsm
`default_nettype wire

// File: rtl/keyboard_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keyboard_ctl : PS/2 scancode stream to held jump/left/right game controls
// Revision 1.0
// ---------------------------------------------------------------------------
module keyboard_ctl
    import keyboard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic       key_jump,
    output logic       key_left,
    output logic       key_right
);

    logic [7:0] w_code;
    logic       w_is_make;
    logic       w_is_break;
    logic       w_is_ext;

    logic r_w, r_a, r_d, r_up, r_lf, r_rt;

    kbd_prefix_fsm u_prefix_fsm (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .code         (w_code),
        .is_make      (w_is_make),
        .is_break     (w_is_break),
        .is_ext       (w_is_ext)
    );

    // A make sets and a break clears only the flag matching code and plane.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w  <= 1'b0;
            r_a  <= 1'b0;
            r_d  <= 1'b0;
            r_up <= 1'b0;
            r_lf <= 1'b0;
            r_rt <= 1'b0;
        end else if (w_is_make || w_is_break) begin
            if (w_is_ext) begin
                if (w_code == SC_UP)    r_up <= w_is_make;
                if (w_code == SC_LEFT)  r_lf <= w_is_make;
                if (w_code == SC_RIGHT) r_rt <= w_is_make;
            end else begin
                if (w_code == SC_W) r_w <= w_is_make;
                if (w_code == SC_A) r_a <= w_is_make;
                if (w_code == SC_D) r_d <= w_is_make;
            end
        end
    end

    assign key_jump  = r_w | r_up;
    assign key_left  = r_a | r_lf;
    assign key_right = r_d | r_rt;

endmodule : keyboard_ctl
`default_nettype wire

// File: tb/tb_keyboard_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keyboard_ctl : directed scoreboard bench for keyboard_ctl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_keyboard_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic       key_jump, key_left, key_right;

    int checks   = 0;
    int failures = 0;

    // Expected {key_jump, key_left, key_right} after each clock edge.
    logic [2:0] exp_q[$];

    keyboard_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .key_jump     (key_jump),
        .key_left     (key_left),
        .key_right    (key_right)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [2:0] exp_v;
        logic [2:0] obs_v;
        checks++;
        obs_v = {key_jump, key_left, key_right};
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%b", tag, obs_v);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs_v === exp_v) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", tag, obs_v, exp_v);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] exp_v, input string tag);
        exp_q.push_back(exp_v);
        @(negedge clk);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
        check(tag);
    endtask

    task automatic idle(input logic [7:0] junk, input logic [2:0] exp_v, input string tag);
        exp_q.push_back(exp_v);
        @(negedge clk);
        rx_data      = junk;
        rx_done_tick = 1'b0;
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic reset_cycle(input logic rand_strobe, input string tag);
        exp_q.push_back(3'b000);
        @(negedge clk);
        rst          = 1'b0;
        rx_data      = 8'($urandom);
        rx_done_tick = rand_strobe ? 1'($urandom) : 1'b0;
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) reset_cycle(1'b1, "reset_hold");
        @(negedge clk);
        rst          = 1'b1;
        rx_done_tick = 1'b0;

        // W make then break, A and D together
        send(8'h1D, 3'b100, "w_make");
        send(8'hF0, 3'b100, "w_brk_prefix");
        send(8'h1D, 3'b000, "w_break");
        send(8'h1C, 3'b010, "a_make");
        send(8'h23, 3'b011, "d_make");
        send(8'hF0, 3'b011, "a_brk_prefix");
        send(8'h1C, 3'b001, "a_break");
        send(8'hF0, 3'b001, "d_brk_prefix");
        send(8'h23, 3'b000, "d_break");

        // W and D held, release W only
        send(8'h1D, 3'b100, "w_make2");
        send(8'h23, 3'b101, "d_make2");
        send(8'hF0, 3'b101, "w_brk_prefix2");
        send(8'h1D, 3'b001, "w_break2");
        send(8'hF0, 3'b001, "d_brk_prefix2");
        send(8'h23, 3'b000, "d_break2");

        // Up and W both drive jump
        send(8'hE0, 3'b000, "up_ext");
        send(8'h75, 3'b100, "up_make");
        send(8'h1D, 3'b100, "w_with_up");
        send(8'hF0, 3'b100, "w_brk_prefix3");
        send(8'h1D, 3'b100, "w_break_up_held");
        send(8'hE0, 3'b100, "up_ext_brk");
        send(8'hF0, 3'b100, "up_brk_prefix");
        send(8'h75, 3'b000, "up_break");

        // Extended left/right, plane separation and typematic repeat
        send(8'hE0, 3'b000, "lf_ext");
        send(8'h6B, 3'b010, "lf_make");
        send(8'h6B, 3'b010, "plain_6b_ignored");
        send(8'hE0, 3'b010, "lf_ext_rep");
        send(8'h6B, 3'b010, "lf_typematic");
        send(8'hE0, 3'b010, "rt_ext");
        send(8'h74, 3'b011, "rt_make");
        send(8'hF0, 3'b011, "a_brk_plain");
        send(8'h1C, 3'b011, "a_break_keeps_lf");
        send(8'hE0, 3'b011, "lf_ext_brk");
        send(8'hF0, 3'b011, "lf_brk_prefix");
        send(8'h6B, 3'b001, "lf_break");
        send(8'hE0, 3'b001, "w_ext_ignored");
        send(8'h1D, 3'b001, "ext_1d_ignored");
        send(8'hE0, 3'b001, "rt_ext_brk");
        send(8'hF0, 3'b001, "rt_brk_prefix");
        send(8'h74, 3'b000, "rt_break");

        // Bytes without a strobe must be ignored
        idle(8'h1D, 3'b000, "no_strobe_1d");
        idle(8'hF0, 3'b000, "no_strobe_f0");
        send(8'h1C, 3'b010, "a_make_after_idle");
        send(8'hF0, 3'b010, "a_brk_prefix4");
        send(8'h1C, 3'b000, "a_break4");

        // Reset mid-sequence discards pending prefix and clears flags
        send(8'h1D, 3'b100, "w_make_pre_rst");
        send(8'hF0, 3'b100, "brk_prefix_pre_rst");
        reset_cycle(1'b0, "mid_reset");
        @(negedge clk);
        rst = 1'b1;
        send(8'h1C, 3'b010, "a_make_post_rst");
        send(8'hF0, 3'b010, "unmapped_brk_prefix");
        send(8'h55, 3'b010, "unmapped_break");
        send(8'h23, 3'b011, "d_make_post_unmapped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_keyboard_ctl
`default_nettype wire
